// File: rtl/clk_gen_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gen_ctrl
//   Run/pause and rate controller for the clock_gen divider of the 0-99
//   counter. It owns clock_gen's clear and bit-select. Every select change
//   is made while the divider is held clear, so the change cannot glitch.
//   The selected divider bit is turned into a one-cycle tick enable for the
//   BCD counter stage.
//
// Ports
//   fsys         in   system clock, all logic on posedge
//   rst_n        in   synchronous reset, active-low
//   run          in   level: 1 = count, 0 = pause
//   rate_up      in   1-cycle pulse: faster (select - 1)
//   rate_dn      in   1-cycle pulse: slower (select + 1)
//   clk_gen_out  in   selected divider bit from clock_gen
//   clk_gen_rst  out  active-high clear to clock_gen (registered)
//   clk_gen_sc   out  bit select to clock_gen (registered)
//   tick         out  1-cycle count enable (registered)
//   busy         out  high while in RESYNC
//   running      out  high in RUN or RESYNC
//   dbg_state_o  out  current FSM state (PAUSE=0, RUN=1, RESYNC=2)
//
// Handshake: there is no valid/ready pair. rate_up and rate_dn are
// fire-and-forget single-cycle pulses. A pulse that cannot be applied in
// the cycle it arrives is dropped, not queued.
// ---------------------------------------------------------------------------
module clk_gen_ctrl #(
  parameter int SIZE       = 32,
  parameter int SC_MIN     = 20,
  parameter int SC_MAX     = 31,
  parameter int SC_DEFAULT = 26
) (
  input  logic                    fsys,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    rate_up,
  input  logic                    rate_dn,
  input  logic                    clk_gen_out,
  output logic                    clk_gen_rst,
  output logic [$clog2(SIZE)-1:0] clk_gen_sc,
  output logic                    tick,
  output logic                    busy,
  output logic                    running,
  output logic [1:0]              dbg_state_o
);

  localparam int SCW = $clog2(SIZE);
  localparam logic [SCW-1:0] SC_MIN_W = SCW'(SC_MIN);
  localparam logic [SCW-1:0] SC_MAX_W = SCW'(SC_MAX);
  localparam logic [SCW-1:0] SC_DEF_W = SCW'(SC_DEFAULT);

  typedef enum logic [1:0] {
    PAUSE  = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SCW-1:0]   sc_q, sc_d;
  logic             gen_rst_q, gen_rst_d;
  logic             tick_q, tick_d;
  logic             prev_q, prev_d;

  // A rate request is only actionable when exactly one button fired and the
  // select is not already at the limit in that direction.
  logic             up_ok;
  logic             dn_ok;
  logic             sc_can_step;
  logic [SCW-1:0]   sc_step;

  assign up_ok       = rate_up & ~rate_dn & (sc_q > SC_MIN_W);
  assign dn_ok       = rate_dn & ~rate_up & (sc_q < SC_MAX_W);
  assign sc_can_step = up_ok | dn_ok;
  assign sc_step     = up_ok ? (sc_q - SCW'(1)) : (sc_q + SCW'(1));

  // -------------------------------------------------------------------------
  // State register and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge fsys) begin
    if (!rst_n) begin
      state_q   <= PAUSE;
      sc_q      <= SC_DEF_W;
      gen_rst_q <= 1'b1;
      tick_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      gen_rst_q <= gen_rst_d;
      tick_q    <= tick_d;
      prev_q    <= prev_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    case (state_q)
      PAUSE: begin
        // If a rate step and run arrive in the same cycle, the step is
        // applied and we stay paused one more cycle. That way the select
        // never moves on the edge where the divider clear is released.
        // run is a level, so RUN follows on the next cycle.
        if (sc_can_step) begin
          sc_d = sc_step;
        end else if (run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = PAUSE;
        end else if (sc_can_step) begin
          sc_d    = sc_step;
          state_d = RESYNC;
        end
      end
      RESYNC: begin
        state_d = run ? RUN : PAUSE;
      end
      default: begin
        state_d = PAUSE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == RESYNC);
    running   = (state_q != PAUSE);
    // The clear is low only in RUN. Deriving it from state_d makes it rise
    // on the same edge the select changes, and fall one edge after the
    // last change.
    gen_rst_d = (state_d != RUN);
    prev_d    = prev_q;
    if (gen_rst_q) begin
      prev_d = 1'b0;
    end else if (state_q == RUN) begin
      prev_d = clk_gen_out;
    end
    tick_d = (state_q == RUN) & clk_gen_out & ~prev_q & ~gen_rst_q;
  end

  assign clk_gen_rst = gen_rst_q;
  assign clk_gen_sc  = sc_q;
  assign tick        = tick_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gen_ctrl
//   Directed bench for clk_gen_ctrl with a small clock_gen divider model
//   (SIZE=8). Tick cycle numbers are predicted from the select and from the
//   edge that last saw the divider clear, pushed into exp_q, and matched by
//   a negedge monitor.
// ---------------------------------------------------------------------------
module tb_clk_gen_ctrl;

  localparam int SIZE = 8;
  localparam int SCW  = $clog2(SIZE);

  // ---------------- clock / reset ----------------
  logic fsys = 1'b0;
  logic rst_n;
  always #5 fsys = ~fsys;

  int cyc = 0;
  always @(posedge fsys) cyc <= cyc + 1;

  // ---------------- DUT + divider model ----------------
  logic           run, rate_up, rate_dn;
  logic           clk_gen_out, clk_gen_rst;
  logic [SCW-1:0] clk_gen_sc;
  logic           tick, busy, running;
  logic [1:0]     dbg_state;

  logic [SIZE-1:0] div_cnt;
  always @(posedge fsys) begin
    if (clk_gen_rst) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end
  assign clk_gen_out = div_cnt[clk_gen_sc];

  clk_gen_ctrl #(
    .SIZE(SIZE), .SC_MIN(1), .SC_MAX(7), .SC_DEFAULT(3)
  ) dut (
    .fsys(fsys), .rst_n(rst_n), .run(run), .rate_up(rate_up),
    .rate_dn(rate_dn), .clk_gen_out(clk_gen_out), .clk_gen_rst(clk_gen_rst),
    .clk_gen_sc(clk_gen_sc), .tick(tick), .busy(busy), .running(running),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ticks(input int first, input int period, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(32'(first + k * period));
  endtask

  // Every cycle: tick must be high exactly on the predicted cycles.
  always @(negedge fsys) begin
    if (mon_en) begin
      logic exp_tick;
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == 32'(cyc));
      checks++;
      assert (tick === exp_tick)
      else begin
        failures++;
        $error("FAIL tick observed=%0b expected=%0b (cycle %0d)", tick, exp_tick, cyc);
      end
      if (exp_tick) void'(exp_q.pop_front());
      while (exp_q.size() > 0 && exp_q[0] < 32'(cyc)) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge fsys);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) cycle();
  endtask

  // One-cycle pulse; on return, cyc is the edge that sampled it.
  task automatic pulse(input logic up, input logic dn);
    rate_up = up;
    rate_dn = dn;
    cycle();
    rate_up = 1'b0;
    rate_dn = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int c, e, f, g, h, p, q, s, u;

  initial begin
    rst_n = 1'b0; run = 1'b0; rate_up = 1'b0; rate_dn = 1'b0;
    repeat (3) cycle();
    chk("rst_sc", 32'(clk_gen_sc), 32'd3);
    chk("rst_clr", 32'(clk_gen_rst), 32'd1);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 1. Idle, paused, for 100 cycles.
    for (int i = 0; i < 10; i++) begin
      repeat (10) cycle();
      chk("idle_sc", 32'(clk_gen_sc), 32'd3);
      chk("idle_clr", 32'(clk_gen_rst), 32'd1);
      chk("idle_running", 32'(running), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // 2. Run at sc=3: first tick 9 edges after the run edge, then every 16.
    c = cyc;
    run = 1'b1;
    push_ticks(c + 10, 16, 10);
    cycle();
    chk("run_clr", 32'(clk_gen_rst), 32'd0);
    chk("run_running", 32'(running), 32'd1);
    wait_to(c + 157);

    // 3. Faster step in RUN: one RESYNC cycle, then sc=2 cadence.
    e = cyc;
    pulse(1'b1, 1'b0);
    chk("up_sc", 32'(clk_gen_sc), 32'd2);
    chk("up_clr", 32'(clk_gen_rst), 32'd1);
    chk("up_busy", 32'(busy), 32'd1);
    cycle();
    chk("up_clr_after", 32'(clk_gen_rst), 32'd0);
    chk("up_busy_after", 32'(busy), 32'd0);
    push_ticks(e + 7, 8, 4);
    wait_to(e + 32);

    // 4a. Step to sc=1, then a faster request at the limit is ignored.
    f = cyc;
    pulse(1'b1, 1'b0);
    chk("up1_sc", 32'(clk_gen_sc), 32'd1);
    push_ticks(f + 5, 4, 3);
    wait_to(f + 14);
    g = cyc;
    pulse(1'b1, 1'b0);
    chk("sat_min_sc", 32'(clk_gen_sc), 32'd1);
    chk("sat_min_busy", 32'(busy), 32'd0);
    chk("sat_min_clr", 32'(clk_gen_rst), 32'd0);
    push_ticks(g + 3, 4, 3);
    wait_to(g + 12);

    // 4b. Pause, walk sc up to 7 (one extra press saturates), run, then a
    //     slower request at the limit and a both-buttons press are ignored.
    h = cyc;
    run = 1'b0;
    cycle();
    chk("pause_clr", 32'(clk_gen_rst), 32'd1);
    chk("pause_running", 32'(running), 32'd0);
    for (int i = 0; i < 7; i++) begin
      pulse(1'b0, 1'b1);
      chk("dn_pause_sc", 32'(clk_gen_sc), 32'((i + 2 > 7) ? 7 : i + 2));
      chk("dn_pause_clr", 32'(clk_gen_rst), 32'd1);
      cycle();
    end
    p = cyc;
    run = 1'b1;
    push_ticks(p + 130, 256, 2);
    wait_to(p + 131);
    q = cyc;
    pulse(1'b0, 1'b1);
    chk("sat_max_sc", 32'(clk_gen_sc), 32'd7);
    chk("sat_max_busy", 32'(busy), 32'd0);
    chk("sat_max_clr", 32'(clk_gen_rst), 32'd0);
    pulse(1'b1, 1'b1);
    chk("both_run_sc", 32'(clk_gen_sc), 32'd7);
    chk("both_run_busy", 32'(busy), 32'd0);
    wait_to(p + 388);

    // 5. Pause, reset to sc=3, both buttons ignored, slower to 4, run.
    run = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("rst2_sc", 32'(clk_gen_sc), 32'd3);
    chk("rst2_clr", 32'(clk_gen_rst), 32'd1);
    rst_n = 1'b1;
    cycle();
    pulse(1'b1, 1'b1);
    chk("both_pause_sc", 32'(clk_gen_sc), 32'd3);
    pulse(1'b0, 1'b1);
    chk("dn_sc4", 32'(clk_gen_sc), 32'd4);
    cycle();
    s = cyc;
    run = 1'b1;
    push_ticks(s + 18, 32, 3);
    cycle();
    chk("run4_clr", 32'(clk_gen_rst), 32'd0);

    // 6. Drop run mid-period; on resume the partial period is lost.
    wait_to(s + 90);
    run = 1'b0;
    wait_to(s + 100);
    run = 1'b1;
    push_ticks(s + 118, 32, 2);
    wait_to(s + 152);

    // Reset during RESYNC: back to sc=3 and PAUSE, no tick.
    u = cyc;
    pulse(1'b0, 1'b1);
    chk("rsy_sc", 32'(clk_gen_sc), 32'd5);
    chk("rsy_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    run = 1'b0;
    cycle();
    chk("rsy_rst_sc", 32'(clk_gen_sc), 32'd3);
    chk("rsy_rst_busy", 32'(busy), 32'd0);
    chk("rsy_rst_running", 32'(running), 32'd0);
    chk("rsy_rst_clr", 32'(clk_gen_rst), 32'd1);
    rst_n = 1'b1;
    repeat (20) cycle();

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
